// File: rtl/aeolus_disp_pkg.sv
// Shared constants for the Aeolus CPU-output display: segment patterns,
// history depth and output bundle type.
package aeolus_disp_pkg;

  localparam int HIST_DEPTH = 4;
  localparam int SCAN_W     = $clog2(HIST_DEPTH);

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [6:0]            seg;
    logic [HIST_DEPTH-1:0] an;
    logic                  dp;
  } disp_t;

  localparam disp_t DISP_BLANK = '{seg: SEG_BLANK, an: {HIST_DEPTH{1'b1}}, dp: 1'b1};

  function automatic logic [HIST_DEPTH-1:0] anode_mask(input logic [SCAN_W-1:0] idx);
    anode_mask = ~(HIST_DEPTH'(1) << idx);
  endfunction

endpackage

// File: rtl/aeolus_seg_decoder.sv
// Combinational nibble to 7-segment decoder. Defining AEOLUS_DISP_HEX_EN
// shows 10-15 as A,b,C,d,E,F; otherwise they show as a dash.
module aeolus_seg_decoder
  import aeolus_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Pattern lookup
  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
`ifdef AEOLUS_DISP_HEX_EN
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      4'hF:    pattern = SEG_F;
`else
      4'hA:    pattern = SEG_DASH;
      4'hB:    pattern = SEG_DASH;
      4'hC:    pattern = SEG_DASH;
      4'hD:    pattern = SEG_DASH;
      4'hE:    pattern = SEG_DASH;
      4'hF:    pattern = SEG_DASH;
`endif
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/aeolus_out_display.sv
// Four-digit scanned display of the CPU output nibble history (digit0 newest).
// Hex digits A-F are shown only when AEOLUS_DISP_HEX_EN is defined.
module aeolus_out_display
  import aeolus_disp_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000
) (
  input  logic       boardCLK,
  input  logic       reset,
  input  logic [3:0] cpuOut,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_COUNT - 1);

  logic [3:0]            sample;
  logic [3:0]            hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid;
  logic [CW-1:0]         cnt;
  logic [SCAN_W-1:0]     scan;

  logic                  capture;
  logic                  wrap;
  logic [6:0]            pattern;
  disp_t                 disp_next;

  assign capture = !hold && (!valid[0] || (sample != hist[0]));
  assign wrap    = (cnt == CNT_LAST);

  aeolus_seg_decoder u_dec (
    .nibble  (hist[scan]),
    .pattern (pattern)
  );

  // Input sample register and nibble history shift
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      sample <= 4'h0;
      valid  <= {HIST_DEPTH{1'b0}};
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist[i] <= 4'h0;
      end
    end else begin
      sample <= cpuOut;
      if (capture) begin
        hist[0] <= sample;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          hist[i] <= hist[i-1];
        end
        valid <= {valid[HIST_DEPTH-2:0], 1'b1};
      end else begin
        valid <= valid;
      end
    end
  end

  // Refresh counter and scan index; the index steps on the wrap cycle
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      cnt  <= {CW{1'b0}};
      scan <= {SCAN_W{1'b0}};
    end else if (wrap) begin
      cnt  <= {CW{1'b0}};
      scan <= scan + SCAN_W'(1);
    end else begin
      cnt  <= cnt + CW'(1);
      scan <= scan;
    end
  end

  // Next display drive: blank unless the scanned digit holds valid data
  always_comb begin
    disp_next = DISP_BLANK;
    if (valid[scan]) begin
      disp_next.seg = pattern;
      disp_next.an  = anode_mask(scan);
      disp_next.dp  = (scan == SCAN_W'(0)) ? 1'b0 : 1'b1;
    end else begin
      disp_next = DISP_BLANK;
    end
  end

  // Registered outputs so seg, an and dp switch on the same edge
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      seg <= DISP_BLANK.seg;
      an  <= DISP_BLANK.an;
      dp  <= DISP_BLANK.dp;
    end else begin
      seg <= disp_next.seg;
      an  <= disp_next.an;
      dp  <= disp_next.dp;
    end
  end

endmodule

// File: doc/aeolus_out_display.md
AEOLUS_OUT_DISPLAY -- requirements
Module: aeolus_out_display

Interface
REQ-001 SHALL have parameter REFRESH_COUNT, default 100000, clock cycles each digit is lit per scan step (minimum 2).
REQ-002 SHALL have port boardCLK, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cpuOut, input, 4, CPU output nibble, synchronous to boardCLK.
REQ-005 SHALL have port hold, input, 1, freezes history capture while high.
REQ-006 SHALL have port seg, output, 7, segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port an, output, 4, digit anode enables, active-low, one-hot-low or all high.
REQ-008 SHALL have port dp, output, 1, decimal point, active-low, lit only on newest digit.

Function
REQ-009 SHALL register cpuOut into sample register every cycle; capture decision uses sample (1-cycle input latency).
REQ-010 SHALL keep a 4-entry nibble history (digit0 newest) plus 4 valid bits.
REQ-011 SHALL shift sample into digit0, digits moving 0->1->2->3, oldest discarded, when hold low and (valid0 low or sample != digit0); history visible on display at most 2 cycles after cpuOut change.
REQ-012 SHALL set valid0 on every shift, shifting valid bits alongside data; once all 4 valid, further shifts discard digit3 without error.
REQ-013 SHALL NOT shift while hold high; a change present when hold falls is captured on the first cycle hold is low.
REQ-014 SHALL run refresh counter 0..REFRESH_COUNT-1, wrapping to 0 and advancing scan index 0->1->2->3->0 on the wrap cycle.
REQ-015 SHALL drive an[i] low only when scan index = i and valid[i] high; otherwise all an high and seg all high (blank).
REQ-016 SHALL drive seg from registered decode of digit[scan index]; seg/an/dp change on the same edge (registered outputs, 1-cycle after scan index).
REQ-017 SHALL decode 0-9 to standard 7-segment patterns.
REQ-018 SHALL drive dp low only when scan index = 0 and valid0 high.
REQ-019 SHALL treat a capture and a scan advance on the same cycle independently; the displayed digit reflects post-shift history from the next cycle.

Reset
REQ-020 SHALL, on reset high at any clock edge, clear history, valid bits, sample, refresh counter and scan index to 0, mid-scan included.
REQ-021 SHALL drive seg=7'h7F, an=4'hF, dp=1 during reset and the cycle after.
REQ-022 SHALL capture the first post-reset sample unconditionally (valid0 low), including value 0.

Configuration
REQ-023 SHALL use macro AEOLUS_DISP_HEX_EN: defined -> nibbles 10-15 shown as A,b,C,d,E,F; undefined -> 10-15 shown as dash (only g lit).
REQ-024 SHALL leave capture, scan and timing identical in both configurations.

Structure
REQ-025 SHALL place segment pattern constants (0-9, A-F, dash, blank) and the history depth constant (4) in shared package aeolus_disp_pkg.
REQ-026 SHALL implement nibble-to-segment decoding in sub-module aeolus_seg_decoder (combinational, honours AEOLUS_DISP_HEX_EN); aeolus_out_display registers its output.

Verification (REFRESH_COUNT=4)
REQ-027 SHALL cover: reset, cpuOut=0 held -> after 2 cycles valid0=1, digit0=0, only an[0] ever low, seg=7'h40, dp=0 when lit.
REQ-028 SHALL cover: cpuOut 1,2,3,4,5 each held 3 cycles -> history {digit3..0}={2,3,4,5}, all four anodes cycle 0->1->2->3, each lit 4 cycles.
REQ-029 SHALL cover: cpuOut=4'hA -> with AEOLUS_DISP_HEX_EN seg=7'h08 on digit0; without, seg=7'h3F.
REQ-030 SHALL cover: hold=1, cpuOut 7->9 -> history unchanged; hold=0 -> digit0=9 next cycle, digit1 previous value.
REQ-031 SHALL cover: reset asserted mid-scan with scan index 2 -> next cycle an=4'hF, seg=7'h7F, counter and index 0.
REQ-032 SHALL cover: cpuOut change on refresh wrap cycle -> no lost capture, no skipped scan step.
